execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage pipeline, directly downstream of the decode/execute pipeline register. It consumes that register's buffered operands and control, computes the ALU result, branch and jump targets, and the destination register. Results are captured in an internal execute/memory pipeline register feeding the memory stage. An optional iterative multiplier stalls the front of the pipe for the duration of a multiply.

## Interface
- No parameters; datapath is fixed at 32 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous squash of the instruction currently in execute
- pc_value  in  32  PC+4 of the instruction in execute
- read_data_0  in  32  operand A (rs)
- read_data_1  in  32  operand B (rt), also the store data
- immediate  in  32  sign-extended immediate
- alu_op  in  3  operation select
- alu_src, reg_dst, branch, jump, mem_read, mem_write, reg_write, mem_reg  in  1 each  decoded control
- rt_addr, rd_addr  in  5 each  candidate destination registers
- stall  out  1  combinational; upstream stages and the decode/execute register hold while high
- alu_result_xm  out  32  registered ALU/multiply result
- store_data_xm  out  32  registered read_data_1
- dest_addr_xm  out  5  registered destination (rd_addr if reg_dst else rt_addr)
- mem_read_xm, mem_write_xm, reg_write_xm, mem_reg_xm  out  1 each  registered control
- pc_redirect_xm  out  1  registered: branch taken or jump
- pc_target_xm  out  32  registered redirect target

## Operation
- Operand B = alu_src ? immediate : read_data_1.
- alu_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed, result 0/1), 101 XOR, 110 MUL, 111 NOR. ADD/SUB wrap modulo 2^32; no overflow flag.
- Branch taken = branch && (read_data_0 == read_data_1). Branch target = pc_value + (immediate << 2), modulo 2^32.
- Jump target = {pc_value[31:28], immediate[25:0], 2'b00}. Jump takes priority over branch when both are set.
- pc_redirect_xm = jump || branch-taken; pc_target_xm = selected target, or 0 when no redirect.
- MUL FSM states:
  - IDLE: if alu_op == 110, latch operands and go to BUSY with counter = 0.
  - BUSY: each cycle is one shift-add step. The product is the low 32 bits of the unsigned product. After the 32nd step, go to DONE.
  - DONE: the product is presented to the XM register, which captures it at the next edge, then the FSM returns to IDLE.
- stall = (IDLE && alu_op == 110) || BUSY.
- While stall is high, XM captures a bubble: mem_read, mem_write, reg_write, mem_reg and pc_redirect are all 0. Data fields are don't-care but are driven to 0.
- flush: at the next edge, XM captures a bubble and the FSM is forced to IDLE, aborting any multiply. flush has priority over all other updates.
- Reset (asynchronous assert): all XM outputs = 0, FSM = IDLE, counter = 0, latched operands = 0. stall therefore reflects only the current alu_op.

## Timing
- Non-MUL ops: 1-cycle latency; inputs present at edge N appear on the XM outputs after edge N.
- MUL accepted at edge N (IDLE→BUSY). BUSY spans edges N+1..N+32, then DONE. XM captures the product at edge N+33.
- stall is high from the cycle MUL is presented until the FSM leaves BUSY: 33 cycles.
- The instruction following the MUL is first consumed in the cycle after DONE.
- Back-to-back MULs: the second is seen in IDLE after DONE and starts a new 33-cycle stall.
- rst_n deassertion is not synchronised here; the top level supplies a synchronised release.

## Configuration
- EX_MUL_EN defined: the MUL FSM, counter and shift-add datapath are compiled in, with behaviour as above.
- EX_MUL_EN undefined: no FSM; stall is tied to 0; alu_op 110 produces alu_result_xm = 0 with 1-cycle latency and passes control through normally.

## Test plan
- Reset mid-multiply: assert rst_n = 0 during BUSY -> all XM outputs 0 immediately; stall follows alu_op only; FSM is in IDLE after release.
- ADD then SUB with alu_src = 0: A = 0x7FFFFFFF, B = 1 -> alu_result_xm = 0x80000000 one cycle later. SUB with A = 5, B = 7 -> 0xFFFFFFFE.
- Branch: branch = 1, A = B = 0x10, pc_value = 0x100, immediate = 0xFFFFFFFF -> pc_redirect_xm = 1, pc_target_xm = 0xFC. With A ≠ B -> redirect 0, target 0.
- MUL (EX_MUL_EN): A = 0x00012345, B = 0x00001000 -> stall high exactly 33 cycles, XM holds bubbles meanwhile, then alu_result_xm = 0x12345000 with reg_write_xm = 1.
- Flush during BUSY: flush = 1 at cycle 10 of the multiply -> stall drops after that edge, the XM bubble has reg_write_xm = 0, and the next instruction executes normally.
- EX_MUL_EN undefined: alu_op = 110 -> stall never asserts; alu_result_xm = 0 after 1 cycle.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/jump resolution and EX/MEM register; 1-cycle latency for non-MUL ops.
// Optional iterative multiply (EX_MUL_EN) holds stall high for 33 cycles and inserts bubbles meanwhile.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] pc_value,
  input  logic [31:0] read_data_0,
  input  logic [31:0] read_data_1,
  input  logic [31:0] immediate,
  input  logic [2:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic        branch,
  input  logic        jump,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        mem_reg,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic [31:0] alu_result_xm,
  output logic [31:0] store_data_xm,
  output logic [4:0]  dest_addr_xm,
  output logic        mem_read_xm,
  output logic        mem_write_xm,
  output logic        reg_write_xm,
  output logic        mem_reg_xm,
  output logic        pc_redirect_xm,
  output logic [31:0] pc_target_xm
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOR = 3'b111;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  dest_addr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_reg;
    logic        pc_redirect;
    logic [31:0] pc_target;
  } xm_t;

  xm_t         xm_d, xm_q;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] mul_res;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic        br_taken;

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t  state_d, state_q;
  logic [4:0]  cnt_d, cnt_q;
  logic [31:0] mcand_d, mcand_q;
  logic [31:0] mplr_d, mplr_q;
  logic [31:0] prod_d, prod_q;

  assign stall   = ((state_q == IDLE) && (alu_op == OP_MUL)) || (state_q == BUSY);
  assign mul_res = prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        IDLE: if (alu_op == OP_MUL) begin
          state_d = BUSY;
          cnt_d   = 5'd0;
          mcand_d = read_data_0;
          mplr_d  = op_b;
          prod_d  = 32'd0;
        end
        BUSY: begin
          // One shift-add step per cycle; only the low 32 product bits are kept.
          prod_d  = prod_q + (mplr_q[0] ? mcand_q : 32'd0);
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      mcand_q <= 32'd0;
      mplr_q  <= 32'd0;
      prod_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
    end
  end
`else
  assign stall   = 1'b0;
  assign mul_res = 32'd0;
`endif

  assign op_b       = alu_src ? immediate : read_data_1;
  assign br_taken   = branch && (read_data_0 == read_data_1);
  assign br_target  = pc_value + {immediate[29:0], 2'b00};
  assign jmp_target = {pc_value[31:28], immediate[25:0], 2'b00};

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      OP_ADD:  alu_res = read_data_0 + op_b;
      OP_SUB:  alu_res = read_data_0 - op_b;
      OP_AND:  alu_res = read_data_0 & op_b;
      OP_OR:   alu_res = read_data_0 | op_b;
      OP_SLT:  alu_res = {31'd0, ($signed(read_data_0) < $signed(op_b))};
      OP_XOR:  alu_res = read_data_0 ^ op_b;
      OP_MUL:  alu_res = mul_res;
      OP_NOR:  alu_res = ~(read_data_0 | op_b);
      default: alu_res = 32'd0;
    endcase
  end

  // Flushed or stalled cycles load an all-zero bubble.
  always_comb begin
    xm_d = '0;
    if (!flush && !stall) begin
      xm_d.alu_result  = alu_res;
      xm_d.store_data  = read_data_1;
      xm_d.dest_addr   = reg_dst ? rd_addr : rt_addr;
      xm_d.mem_read    = mem_read;
      xm_d.mem_write   = mem_write;
      xm_d.reg_write   = reg_write;
      xm_d.mem_reg     = mem_reg;
      xm_d.pc_redirect = jump || br_taken;
      xm_d.pc_target   = jump ? jmp_target : (br_taken ? br_target : 32'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xm_q <= '0;
    else        xm_q <= xm_d;
  end

  assign alu_result_xm  = xm_q.alu_result;
  assign store_data_xm  = xm_q.store_data;
  assign dest_addr_xm   = xm_q.dest_addr;
  assign mem_read_xm    = xm_q.mem_read;
  assign mem_write_xm   = xm_q.mem_write;
  assign reg_write_xm   = xm_q.reg_write;
  assign mem_reg_xm     = xm_q.mem_reg;
  assign pc_redirect_xm = xm_q.pc_redirect;
  assign pc_target_xm   = xm_q.pc_target;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; multiply-specific steps only apply when EX_MUL_EN is defined.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [31:0] pc_value, read_data_0, read_data_1, immediate;
  logic [2:0]  alu_op;
  logic        alu_src, reg_dst, branch, jump, mem_read, mem_write, reg_write, mem_reg;
  logic [4:0]  rt_addr, rd_addr;
  logic        stall;
  logic [31:0] alu_result_xm, store_data_xm, pc_target_xm;
  logic [4:0]  dest_addr_xm;
  logic        mem_read_xm, mem_write_xm, reg_write_xm, mem_reg_xm, pc_redirect_xm;

  int checks = 0;
  int failures = 0;
  int stall_cycles;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pc_value(pc_value),
    .read_data_0(read_data_0), .read_data_1(read_data_1), .immediate(immediate),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch), .jump(jump),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_reg(mem_reg),
    .rt_addr(rt_addr), .rd_addr(rd_addr), .stall(stall),
    .alu_result_xm(alu_result_xm), .store_data_xm(store_data_xm), .dest_addr_xm(dest_addr_xm),
    .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm), .reg_write_xm(reg_write_xm),
    .mem_reg_xm(mem_reg_xm), .pc_redirect_xm(pc_redirect_xm), .pc_target_xm(pc_target_xm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    pc_value = 32'h0; read_data_0 = 32'h0; read_data_1 = 32'h0; immediate = 32'h0;
    alu_op = 3'b000; alu_src = 1'b0; reg_dst = 1'b0; branch = 1'b0; jump = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_reg = 1'b0;
    rt_addr = 5'd0; rd_addr = 5'd0;
    #2;
    chk("rst_alu", alu_result_xm, 32'h0);
    chk("rst_regwr", {31'd0, reg_write_xm}, 32'h0);
    chk("rst_redir", {31'd0, pc_redirect_xm}, 32'h0);
    chk("rst_target", pc_target_xm, 32'h0);
    chk("rst_dest", {27'd0, dest_addr_xm}, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    tick;
    rst_n = 1'b1;
    tick;

    // ADD wraps into the sign bit; reg_dst selects rd
    read_data_0 = 32'h7FFFFFFF; read_data_1 = 32'h1; alu_op = 3'b000;
    reg_write = 1'b1; reg_dst = 1'b1; rd_addr = 5'd9; rt_addr = 5'd3;
    tick;
    chk("add", alu_result_xm, 32'h80000000);
    chk("add_dest", {27'd0, dest_addr_xm}, 32'd9);
    chk("add_regwr", {31'd0, reg_write_xm}, 32'd1);
    chk("add_store", store_data_xm, 32'h1);

    read_data_0 = 32'd5; read_data_1 = 32'd7; alu_op = 3'b001; reg_dst = 1'b0;
    tick;
    chk("sub", alu_result_xm, 32'hFFFFFFFE);
    chk("sub_dest", {27'd0, dest_addr_xm}, 32'd3);

    // Immediate operand path
    alu_src = 1'b1; read_data_0 = 32'hF0F0_1234; read_data_1 = 32'hDEAD_BEEF; immediate = 32'h0FF0_FF00;
    alu_op = 3'b010; tick; chk("and", alu_result_xm, 32'h00F0_1200);
    alu_op = 3'b011; tick; chk("or",  alu_result_xm, 32'hFFF0_FF34);
    alu_op = 3'b101; tick; chk("xor", alu_result_xm, 32'hFF00_ED34);
    alu_op = 3'b111; tick; chk("nor", alu_result_xm, 32'h000F_00CB);
    chk("imm_store", store_data_xm, 32'hDEAD_BEEF);

    alu_op = 3'b100; read_data_0 = 32'hFFFFFFFF; immediate = 32'd1;
    tick; chk("slt_neg", alu_result_xm, 32'd1);
    read_data_0 = 32'd1; immediate = 32'hFFFFFFFF;
    tick; chk("slt_pos", alu_result_xm, 32'd0);

    // Memory control passthrough
    alu_op = 3'b000; alu_src = 1'b0; mem_read = 1'b1; mem_reg = 1'b1; mem_write = 1'b0;
    tick;
    chk("mem_read", {31'd0, mem_read_xm}, 32'd1);
    chk("mem_reg", {31'd0, mem_reg_xm}, 32'd1);
    chk("mem_write", {31'd0, mem_write_xm}, 32'd0);
    mem_read = 1'b0; mem_reg = 1'b0; mem_write = 1'b1; reg_write = 1'b0;
    tick;
    chk("mem_write2", {31'd0, mem_write_xm}, 32'd1);
    mem_write = 1'b0; reg_write = 1'b1;

    // Branches and jumps
    branch = 1'b1; read_data_0 = 32'h10; read_data_1 = 32'h10;
    pc_value = 32'h100; immediate = 32'hFFFFFFFF;
    tick;
    chk("br_taken", {31'd0, pc_redirect_xm}, 32'd1);
    chk("br_target", pc_target_xm, 32'h000000FC);
    read_data_1 = 32'h11;
    tick;
    chk("br_not", {31'd0, pc_redirect_xm}, 32'd0);
    chk("br_not_tgt", pc_target_xm, 32'd0);
    read_data_1 = 32'h10; jump = 1'b1; pc_value = 32'hA0000004; immediate = 32'h00123456;
    tick;
    chk("jmp_redir", {31'd0, pc_redirect_xm}, 32'd1);
    chk("jmp_prio", pc_target_xm, 32'hA048D158);
    branch = 1'b0; jump = 1'b0;

    // Flush squashes the instruction in execute
    flush = 1'b1; read_data_0 = 32'd2; read_data_1 = 32'd3; alu_op = 3'b000;
    tick;
    chk("flush_regwr", {31'd0, reg_write_xm}, 32'd0);
    chk("flush_alu", alu_result_xm, 32'd0);
    flush = 1'b0;
    tick;
    chk("post_flush", alu_result_xm, 32'd5);

`ifdef EX_MUL_EN
    read_data_0 = 32'h00012345; read_data_1 = 32'h00001000; alu_op = 3'b110; reg_write = 1'b1;
    #1;
    chk("mul_stall0", {31'd0, stall}, 32'd1);
    stall_cycles = 1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (!stall) break;
      stall_cycles++;
      chk("mul_bubble", {31'd0, reg_write_xm}, 32'd0);
    end
    chk("mul_stall_len", stall_cycles, 32'd33);
    tick;
    chk("mul_result", alu_result_xm, 32'h12345000);
    chk("mul_regwr", {31'd0, reg_write_xm}, 32'd1);
    read_data_0 = 32'd4; read_data_1 = 32'd6; alu_op = 3'b000;
    tick;
    chk("after_mul", alu_result_xm, 32'd10);

    // Flush at the tenth cycle of a multiply
    read_data_0 = 32'd3; read_data_1 = 32'd3; alu_op = 3'b110;
    for (int i = 0; i < 9; i++) tick;
    chk("fl_busy", {31'd0, stall}, 32'd1);
    flush = 1'b1; alu_op = 3'b000;
    tick;
    flush = 1'b0;
    chk("fl_stall", {31'd0, stall}, 32'd0);
    chk("fl_bubble", {31'd0, reg_write_xm}, 32'd0);
    read_data_0 = 32'd8; read_data_1 = 32'd1; alu_op = 3'b001;
    tick;
    chk("fl_next", alu_result_xm, 32'd7);
    chk("fl_next_rw", {31'd0, reg_write_xm}, 32'd1);

    // Asynchronous reset while busy
    alu_op = 3'b110;
    for (int i = 0; i < 5; i++) tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mul_alu", alu_result_xm, 32'd0);
    chk("rst_mul_stall", {31'd0, stall}, 32'd1);
    alu_op = 3'b000; read_data_0 = 32'd20; read_data_1 = 32'd22;
    #1;
    chk("rst_mul_stall_add", {31'd0, stall}, 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_idle_stall", {31'd0, stall}, 32'd0);
    chk("rst_idle_add", alu_result_xm, 32'd42);
`else
    read_data_0 = 32'h00012345; read_data_1 = 32'h00001000; alu_op = 3'b110; reg_write = 1'b1;
    #1;
    chk("nomul_stall", {31'd0, stall}, 32'd0);
    tick;
    chk("nomul_result", alu_result_xm, 32'd0);
    chk("nomul_regwr", {31'd0, reg_write_xm}, 32'd1);
    chk("nomul_stall2", {31'd0, stall}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
